// File: rtl/sha1_pkg.sv
// SHA-1 shared definitions: initial chaining value, round constants,
// engine state encoding, rotate helper and the per-round f/K selection.
package sha1_pkg;

  localparam int unsigned NUM_ROUNDS = 80;

  localparam logic [31:0] SHA1_IV [0:4] = '{
    32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
  };

  localparam logic [31:0] SHA1_K [0:3] = '{
    32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hCA62C1D6
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } sha1_state_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Returns {f_t(b,c,d), K_t} for round t.
  function automatic logic [63:0] round_fk(input logic [6:0] t,
                                           input logic [31:0] b,
                                           input logic [31:0] c,
                                           input logic [31:0] d);
    logic [31:0] f;
    logic [31:0] k;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = SHA1_K[0];
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = SHA1_K[1];
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = SHA1_K[2];
    end else begin
      f = b ^ c ^ d;
      k = SHA1_K[3];
    end
    return {f, k};
  endfunction

endpackage

// File: rtl/sha1_wsched.sv
// SHA-1 message schedule: 16-word sliding window.
//   clk, reset_n : clock, async active-low reset
//   load         : capture block (W0 = block[511:480])
//   shift        : advance window by RPC words, appending expanded words
//   block        : 512-bit input block
//   w_out        : W_cnt .. W_cnt+RPC-1, word j at [j*32 +: 32]
module sha1_wsched
  import sha1_pkg::*;
#(
  parameter int unsigned RPC = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [511:0]      block,
  output logic [RPC*32-1:0] w_out
);

  logic [31:0] w_q [0:15];
  logic [31:0] w_d [0:15];
  logic [31:0] ext [0:15+RPC];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) ext[i] = w_q[i];
    // Ascending order lets words produced earlier in this clock feed later
    // ones (needed once RPC exceeds 3).
    for (int unsigned j = 0; j < RPC; j++) begin
      ext[16+j] = rotl(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j], 1);
    end

    w_out = '0;
    for (int unsigned j = 0; j < RPC; j++) w_out[j*32 +: 32] = ext[j];

    for (int unsigned i = 0; i < 16; i++) w_d[i] = w_q[i];
    if (load) begin
      for (int unsigned i = 0; i < 16; i++) w_d[i] = block[511-32*i -: 32];
    end else if (shift) begin
      for (int unsigned i = 0; i < 16; i++) w_d[i] = ext[i+RPC];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end
  end

endmodule

// File: rtl/sha1_compress_core.sv
// Sequential SHA-1 compression engine, RPC rounds per clock.
//   in_valid/in_ready/in_block/in_first/in_last : block input handshake
//   out_valid/out_ready/out_digest              : digest output handshake
//   busy                                        : engine not idle
// Chaining value H persists across blocks; in_first reloads the IV.
module sha1_compress_core
  import sha1_pkg::*;
#(
  parameter int unsigned RPC = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] out_digest,
  output logic         busy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5)) begin : g_rpc_check
    $error("sha1_compress_core: RPC must be 1, 2, 4 or 5");
  end

  localparam logic [6:0] LAST_CNT = 7'(NUM_ROUNDS - RPC);

  sha1_state_e state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d;
  logic [31:0]  h_q [0:4];
  logic [31:0]  h_d [0:4];
  logic         last_q, last_d;
  logic [159:0] digest_q, digest_d;
  logic         sched_load, sched_shift;
  logic [RPC*32-1:0] w_win;

  sha1_wsched #(.RPC(RPC)) u_wsched (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (sched_load),
    .shift  (sched_shift),
    .block  (in_block),
    .w_out  (w_win)
  );

  // Chain of RPC combinational rounds; stage g processes round cnt_q+g.
  for (genvar g = 0; g < RPC; g++) begin : g_round
    logic [31:0] a_i, b_i, c_i, d_i, e_i;
    logic [31:0] a_o, b_o, c_o, d_o, e_o;
    logic [6:0]  t;
    logic [63:0] fk;

    if (g == 0) begin : g_src
      assign a_i = a_q;
      assign b_i = b_q;
      assign c_i = c_q;
      assign d_i = d_q;
      assign e_i = e_q;
    end else begin : g_chain
      assign a_i = g_round[g-1].a_o;
      assign b_i = g_round[g-1].b_o;
      assign c_i = g_round[g-1].c_o;
      assign d_i = g_round[g-1].d_o;
      assign e_i = g_round[g-1].e_o;
    end

    assign t   = cnt_q + 7'(g);
    assign fk  = round_fk(t, b_i, c_i, d_i);
    assign a_o = rotl(a_i, 5) + fk[63:32] + e_i + fk[31:0] + w_win[g*32 +: 32];
    assign b_o = a_i;
    assign c_o = rotl(b_i, 30);
    assign d_o = c_i;
    assign e_o = d_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    e_d         = e_q;
    for (int unsigned i = 0; i < 5; i++) h_d[i] = h_q[i];
    last_d      = last_q;
    digest_d    = digest_q;
    sched_load  = 1'b0;
    sched_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = RUN;
          cnt_d      = '0;
          last_d     = in_last;
          sched_load = 1'b1;
          if (in_first) begin
            a_d = SHA1_IV[0];
            b_d = SHA1_IV[1];
            c_d = SHA1_IV[2];
            d_d = SHA1_IV[3];
            e_d = SHA1_IV[4];
            for (int unsigned i = 0; i < 5; i++) h_d[i] = SHA1_IV[i];
          end else begin
            a_d = h_q[0];
            b_d = h_q[1];
            c_d = h_q[2];
            d_d = h_q[3];
            e_d = h_q[4];
          end
        end
      end
      RUN: begin
        sched_shift = 1'b1;
        a_d = g_round[RPC-1].a_o;
        b_d = g_round[RPC-1].b_o;
        c_d = g_round[RPC-1].c_o;
        d_d = g_round[RPC-1].d_o;
        e_d = g_round[RPC-1].e_o;
        // Counter cleared on the last step so it never leaves the 0..80-RPC range.
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q + 7'(RPC);
        end
      end
      FINAL: begin
        h_d[0] = h_q[0] + a_q;
        h_d[1] = h_q[1] + b_q;
        h_d[2] = h_q[2] + c_q;
        h_d[3] = h_q[3] + d_q;
        h_d[4] = h_q[4] + e_q;
        if (last_q) begin
          digest_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4]};
          state_d  = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      e_q      <= '0;
      for (int unsigned i = 0; i < 5; i++) h_q[i] <= SHA1_IV[i];
      last_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      e_q      <= e_d;
      for (int unsigned i = 0; i < 5; i++) h_q[i] <= h_d[i];
      last_q   <= last_d;
      digest_q <= digest_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_digest = digest_q;

endmodule
